// File: rtl/ch_fnd_display.sv
// Channel display driver: shows "CH" plus the decimal channel on a 4-digit
// common-anode 7-segment display, scanned per tick, blinking after each change.
module ch_fnd_display #(
  parameter int SCAN_TICKS  = 100,
  parameter int BLINK_TICKS = 25_000,
  parameter int BLINK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick,
  input  logic [3:0] ch,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int SW = (SCAN_TICKS  > 1) ? $clog2(SCAN_TICKS)      : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS)     : 1;
  localparam int RW = (BLINK_COUNT > 0) ? $clog2(BLINK_COUNT + 1) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [RW-1:0] REMAIN_INI = RW'(BLINK_COUNT);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_ONE   = 8'hF9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BLINK_OFF = 2'd1,
    ST_BLINK_ON  = 2'd2
  } state_t;

  logic [3:0]    r_ch_q;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;
  state_t        r_state;
  logic [BW-1:0] r_blink_cnt;
  logic [RW-1:0] r_remain;
  logic [7:0]    r_seg;
  logic [3:0]    r_an;

  state_t        w_state_nxt;
  logic [BW-1:0] w_blink_cnt_nxt;
  logic [RW-1:0] w_remain_nxt;
  logic          w_change;
  logic          w_half_done;
  logic          w_tens;
  logic [3:0]    w_ones;
  logic          w_num_blank;
  logic [7:0]    w_seg;
  logic [3:0]    w_an;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign w_change    = (ch != r_ch_q);
  assign w_half_done = tick && (r_blink_cnt == BLINK_LAST);

  // NOTE: every sequential block uses <= so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ch_q     <= 4'd0;
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else begin
      r_ch_q <= ch;
      if (tick) begin
        if (r_scan_cnt == SCAN_LAST) begin
          r_scan_cnt <= '0;
          r_idx      <= r_idx + 2'd1;
        end else begin
          r_scan_cnt <= r_scan_cnt + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_blink_cnt <= '0;
      r_remain    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_remain    <= w_remain_nxt;
    end
  end

  // A change restarts the blink and swallows any tick arriving in the same clk.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    w_state_nxt     = r_state;
    w_blink_cnt_nxt = r_blink_cnt;
    w_remain_nxt    = r_remain;
    if (w_change && (BLINK_COUNT > 0)) begin
      w_state_nxt     = ST_BLINK_OFF;
      w_blink_cnt_nxt = '0;
      w_remain_nxt    = REMAIN_INI;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_BLINK_OFF: begin
          if (w_half_done) begin
            w_state_nxt     = ST_BLINK_ON;
            w_blink_cnt_nxt = '0;
          end else if (tick) begin
            w_blink_cnt_nxt = r_blink_cnt + BW'(1);
          end
        end
        ST_BLINK_ON: begin
          if (w_half_done) begin
            w_blink_cnt_nxt = '0;
            w_remain_nxt    = r_remain - RW'(1);
            w_state_nxt     = (r_remain == RW'(1)) ? ST_IDLE : ST_BLINK_OFF;
          end else if (tick) begin
            w_blink_cnt_nxt = r_blink_cnt + BW'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_tens      = (r_ch_q >= 4'd10);
  assign w_ones      = w_tens ? (r_ch_q - 4'd10) : r_ch_q;
  assign w_num_blank = (r_state == ST_BLINK_OFF);
  assign w_an        = ~(4'b0001 << r_idx);

  always_comb begin
    w_seg = SEG_BLANK;
    case (r_idx)
      2'd0: w_seg = w_num_blank ? SEG_BLANK : seg7(w_ones);
      2'd1: w_seg = (w_num_blank || !w_tens) ? SEG_BLANK : SEG_ONE;
      2'd2: w_seg = SEG_H;
      2'd3: w_seg = SEG_C;
      default: w_seg = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seg <= SEG_BLANK;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
